// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter that shares one SD sector read/write engine
// between NUM_CH client channels, with start and busy timeouts.
module sd_cmd_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int START_TO = 255,
    parameter int BUSY_TO  = 65535,
    localparam int GW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic                 sd_init_done,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_wr,
    input  logic [NUM_CH*32-1:0] ch_sec_addr,
    input  logic [NUM_CH*16-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [NUM_CH-1:0]    ch_wr_req,
    output logic [NUM_CH-1:0]    ch_rd_val_en,
    output logic [15:0]          ch_rd_data,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_err,
    output logic                 eng_wr_start,
    output logic                 eng_rd_start,
    output logic [31:0]          eng_sec_addr,
    output logic [15:0]          eng_wr_data,
    input  logic                 eng_wr_busy,
    input  logic                 eng_rd_busy,
    input  logic                 eng_wr_req,
    input  logic                 eng_rd_val_en,
    input  logic [15:0]          eng_rd_data,
    output logic                 arb_busy,
    output logic [GW-1:0]        grant
);

    localparam logic [15:0] START_LIM = 16'(START_TO);
    localparam logic [15:0] BUSY_LIM  = 16'(BUSY_TO);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          dir_q, dir_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;

    logic              found;
    logic [GW-1:0]     sel;
    logic [31:0]       sel_addr;
    logic              sel_wr;
    logic [NUM_CH-1:0] gsel;
    logic              busy_sel;

    // Round-robin pick: first requester at or after grant+1, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = grant_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && ch_req[i] &&
                    i == (int'(grant_q) + k) % NUM_CH) begin
                    found = 1'b1;
                    sel   = GW'(i);
                end
            end
        end
    end

    // Fields of the candidate channel, plus one-hot decode of the grant.
    always_comb begin
        sel_addr    = '0;
        sel_wr      = 1'b0;
        eng_wr_data = '0;
        gsel        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == GW'(i)) begin
                sel_addr = ch_sec_addr[i*32 +: 32];
                sel_wr   = ch_wr[i];
            end
            if (grant_q == GW'(i)) begin
                eng_wr_data = ch_wr_data[i*16 +: 16];
                gsel[i]     = 1'b1;
            end
        end
    end

    // Only the engine matching the latched direction is watched.
    assign busy_sel = dir_q ? eng_wr_busy : eng_rd_busy;

    // Next-state logic and timeout counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sd_init_done && found) begin
                    grant_d = sel;
                    dir_d   = sel_wr;
                    addr_d  = sel_addr;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_sel) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (cnt_q == START_LIM) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!busy_sel) begin
                    state_d = DONE;
                end else if (cnt_q == BUSY_LIM) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transfer context registers.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_CH - 1);
            dir_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses and strobe routing decoded from state and grant.
    always_comb begin
        arb_busy     = (state_q != IDLE);
        ch_ack       = gsel & {NUM_CH{state_q == LAUNCH}};
        ch_done      = gsel & {NUM_CH{state_q == DONE}};
        ch_err       = gsel & {NUM_CH{state_q == ERR}};
        eng_wr_start = (state_q == LAUNCH) & dir_q;
        eng_rd_start = (state_q == LAUNCH) & ~dir_q;
        ch_wr_req    = gsel & {NUM_CH{eng_wr_req & arb_busy}};
        ch_rd_val_en = gsel & {NUM_CH{eng_rd_val_en & arb_busy}};
    end

    assign ch_rd_data   = eng_rd_data;
    assign eng_sec_addr = addr_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: stimulus queues expected
// ack/done/err events, a monitor pops them as the DUT pulses.
module tb_sd_cmd_arbiter;

    localparam int N        = 4;
    localparam int START_TO = 255;
    localparam int BUSY_TO  = 300;
    localparam int K_ACK    = 1;
    localparam int K_DONE   = 2;
    localparam int K_ERR    = 3;

    logic           clk_ref = 1'b0;
    logic           rst;
    logic           sd_init_done;
    logic [N-1:0]   ch_req;
    logic [N-1:0]   ch_wr;
    logic [N*32-1:0] ch_sec_addr;
    logic [N*16-1:0] ch_wr_data;
    logic [N-1:0]   ch_ack;
    logic [N-1:0]   ch_wr_req;
    logic [N-1:0]   ch_rd_val_en;
    logic [15:0]    ch_rd_data;
    logic [N-1:0]   ch_done;
    logic [N-1:0]   ch_err;
    logic           eng_wr_start;
    logic           eng_rd_start;
    logic [31:0]    eng_sec_addr;
    logic [15:0]    eng_wr_data;
    logic           eng_wr_busy;
    logic           eng_rd_busy;
    logic           eng_wr_req;
    logic           eng_rd_val_en;
    logic [15:0]    eng_rd_data;
    logic           arb_busy;
    logic [1:0]     grant;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_q[$];

    int   eng_mode  = 0;
    int   busy_len  = 10;
    int   wr_pulses = 0;
    logic eng_active = 1'b0;
    logic keep = 1'b0;

    int wr_cnt[N];
    int rv_cnt[N];
    int n_ack = 0;
    int ack_cyc = 0;
    int err_cyc = 0;

    sd_cmd_arbiter #(
        .NUM_CH  (N),
        .START_TO(START_TO),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk_ref      (clk_ref),
        .rst          (rst),
        .sd_init_done (sd_init_done),
        .ch_req       (ch_req),
        .ch_wr        (ch_wr),
        .ch_sec_addr  (ch_sec_addr),
        .ch_wr_data   (ch_wr_data),
        .ch_ack       (ch_ack),
        .ch_wr_req    (ch_wr_req),
        .ch_rd_val_en (ch_rd_val_en),
        .ch_rd_data   (ch_rd_data),
        .ch_done      (ch_done),
        .ch_err       (ch_err),
        .eng_wr_start (eng_wr_start),
        .eng_rd_start (eng_rd_start),
        .eng_sec_addr (eng_sec_addr),
        .eng_wr_data  (eng_wr_data),
        .eng_wr_busy  (eng_wr_busy),
        .eng_rd_busy  (eng_rd_busy),
        .eng_wr_req   (eng_wr_req),
        .eng_rd_val_en(eng_rd_val_en),
        .eng_rd_data  (eng_rd_data),
        .arb_busy     (arb_busy),
        .grant        (grant)
    );

    always #5 clk_ref = ~clk_ref;

    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(int kind, int ch);
        exp_q.push_back(kind * 16 + ch);
    endfunction

    task automatic expect_evt(int kind, int ch);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d ch %0d expected none",
                     kind, ch);
        end else begin
            e = exp_q.pop_front();
            check("event(kind*16+ch)", kind * 16 + ch, e);
        end
    endtask

    // Monitor: count strobes and match pulses against the scoreboard.
    initial begin
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0;
            rv_cnt[i] = 0;
        end
        forever begin
            @(negedge clk_ref);
            for (int i = 0; i < N; i++) begin
                if (ch_wr_req[i]) wr_cnt[i]++;
                if (ch_rd_val_en[i]) rv_cnt[i]++;
                if (ch_ack[i]) begin
                    n_ack++;
                    ack_cyc = cyc;
                    expect_evt(K_ACK, i);
                    check("ack_grant", grant, i);
                end
                if (ch_done[i]) expect_evt(K_DONE, i);
                if (ch_err[i]) begin
                    err_cyc = cyc;
                    expect_evt(K_ERR, i);
                end
            end
        end
    end

    // Engine model: start -> busy for busy_len cycles with data strobes.
    initial begin
        logic is_wr;
        eng_wr_busy   = 1'b0;
        eng_rd_busy   = 1'b0;
        eng_wr_req    = 1'b0;
        eng_rd_val_en = 1'b0;
        eng_rd_data   = 16'h5A5A;
        forever begin
            @(negedge clk_ref);
            if (eng_wr_start || eng_rd_start) begin
                is_wr = eng_wr_start;
                eng_active = 1'b1;
                if (eng_mode != 1) begin
                    @(posedge clk_ref);
                    #1;
                    if (is_wr) eng_wr_busy = 1'b1;
                    else eng_rd_busy = 1'b1;
                    for (int i = 0; i < busy_len; i++) begin
                        if (is_wr) eng_wr_req = (i < wr_pulses);
                        else eng_rd_val_en = (i < 8);
                        @(posedge clk_ref);
                        #1;
                    end
                    eng_wr_req    = 1'b0;
                    eng_rd_val_en = 1'b0;
                    eng_wr_busy   = 1'b0;
                    eng_rd_busy   = 1'b0;
                end
                eng_active = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk_ref);
        #1;
        if (!keep) ch_req = ch_req & ~ch_ack;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((ch_req != 0 || arb_busy || eng_active) && n < budget);
        if (ch_req != 0 || arb_busy || eng_active) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle",
                     budget);
            ch_req = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int base[N];
        int b_ack;
        rst          = 1'b1;
        sd_init_done = 1'b1;
        ch_req       = '0;
        ch_wr        = '0;
        for (int i = 0; i < N; i++) begin
            ch_sec_addr[i*32 +: 32] = 32'h1000_0000 + i;
            ch_wr_data[i*16 +: 16]  = 16'hA000 + 16'(i);
        end
        repeat (3) step();
        check("rst_grant", grant, N - 1);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_eng_sec_addr", eng_sec_addr, 0);
        check("rst_pulses",
              {ch_ack, ch_done, ch_err, eng_wr_start, eng_rd_start}, 0);
        rst = 1'b0;

        // Two reads on channels 0 and 2.
        for (int i = 0; i < N; i++) base[i] = rv_cnt[i];
        push(K_ACK, 0); push(K_DONE, 0);
        push(K_ACK, 2); push(K_DONE, 2);
        ch_req = 4'b0101;
        drain(100);
        check("rd_val_ch0", rv_cnt[0] - base[0], 8);
        check("rd_val_ch2", rv_cnt[2] - base[2], 8);
        check("rd_val_ch1_ch3", rv_cnt[1] - base[1] + rv_cnt[3] - base[3], 0);
        check("rd_data_bcast", ch_rd_data, 16'h5A5A);

        // All four requesting continuously after reset.
        do_reset();
        push(K_ACK, 0); push(K_DONE, 0);
        push(K_ACK, 1); push(K_DONE, 1);
        push(K_ACK, 2); push(K_DONE, 2);
        push(K_ACK, 3); push(K_DONE, 3);
        push(K_ACK, 0); push(K_DONE, 0);
        b_ack = n_ack;
        keep = 1'b1;
        ch_req = 4'b1111;
        for (int n = 0; n < 200 && n_ack < b_ack + 5; n++) step();
        check("rr_ack_count", n_ack - b_ack, 5);
        ch_req = '0;
        keep = 1'b0;
        drain(100);

        // Channel 1 write with 256 data requests.
        ch_sec_addr[1*32 +: 32] = 32'h0000_1234;
        ch_wr_data[1*16 +: 16]  = 16'hBEEF;
        ch_wr     = 4'b0010;
        busy_len  = 260;
        wr_pulses = 256;
        for (int i = 0; i < N; i++) base[i] = wr_cnt[i];
        push(K_ACK, 1); push(K_DONE, 1);
        ch_req = 4'b0010;
        drain(400);
        check("wr_sec_addr", eng_sec_addr, 32'h1234);
        check("wr_req_ch1", wr_cnt[1] - base[1], 256);
        check("wr_req_others",
              wr_cnt[0] - base[0] + wr_cnt[2] - base[2] + wr_cnt[3] - base[3], 0);
        check("wr_data_mux", eng_wr_data, 16'hBEEF);
        check("wr_grant", grant, 1);
        ch_wr     = '0;
        wr_pulses = 0;
        busy_len  = 10;

        // Engine never goes busy: start timeout, then normal service.
        eng_mode = 1;
        push(K_ACK, 3); push(K_ERR, 3);
        ch_req = 4'b1000;
        drain(400);
        check("start_to_latency", err_cyc - ack_cyc, START_TO + 2);
        eng_mode = 0;
        push(K_ACK, 0); push(K_DONE, 0);
        ch_req = 4'b0001;
        drain(100);

        // Engine stuck busy: busy timeout.
        busy_len = 400;
        push(K_ACK, 2); push(K_ERR, 2);
        ch_req = 4'b0100;
        drain(600);
        check("busy_to_latency", err_cyc - ack_cyc, BUSY_TO + 3);
        busy_len = 50;

        // Reset in the middle of a transfer.
        push(K_ACK, 1);
        ch_req = 4'b0010;
        repeat (8) step();
        check("run_arb_busy", arb_busy, 1);
        do_reset();
        check("midrst_arb_busy", arb_busy, 0);
        check("midrst_grant", grant, 3);
        drain(100);
        busy_len = 10;

        // Withdrawn request while not initialised has no effect.
        sd_init_done = 1'b0;
        ch_req = 4'b0010;
        repeat (3) step();
        ch_req = '0;
        sd_init_done = 1'b1;
        repeat (6) step();
        check("withdraw_idle", arb_busy, 0);

        // No grants until the card is initialised.
        sd_init_done = 1'b0;
        b_ack = n_ack;
        ch_req = 4'b1111;
        repeat (10) step();
        check("noinit_acks", n_ack - b_ack, 0);
        check("noinit_idle", arb_busy, 0);
        push(K_ACK, 0); push(K_DONE, 0);
        push(K_ACK, 1); push(K_DONE, 1);
        push(K_ACK, 2); push(K_DONE, 2);
        push(K_ACK, 3); push(K_DONE, 3);
        sd_init_done = 1'b1;
        drain(200);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of client channels (2..8).
REQ-002 The module SHALL have parameter START_TO, default 255, giving the maximum cycles from engine start to engine busy.
REQ-003 The module SHALL have parameter BUSY_TO, default 65535, giving the maximum cycles engine busy may stay high; the timeout counter is 16 bits wide.
REQ-004 The module SHALL have derived parameter GW = max(1, clog2(NUM_CH)).
REQ-005 Port: clk_ref  in  1  single clock; all logic rising-edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: sd_init_done  in  1  card initialised; no grants while 0.
REQ-008 Port: ch_req  in  NUM_CH  per-channel request valid; held until ch_ack.
REQ-009 Port: ch_wr  in  NUM_CH  per-channel direction (1 = sector write, 0 = sector read).
REQ-010 Port: ch_sec_addr  in  NUM_CH*32  per-channel sector address; channel i occupies bits [32i+31:32i].
REQ-011 Port: ch_wr_data  in  NUM_CH*16  per-channel write data; channel i occupies bits [16i+15:16i].
REQ-012 Port: ch_ack  out  NUM_CH  one-cycle pulse when the channel's request is accepted.
REQ-013 Port: ch_wr_req  out  NUM_CH  engine write-data request, routed to the granted channel.
REQ-014 Port: ch_rd_val_en  out  NUM_CH  engine read-valid, routed to the granted channel.
REQ-015 Port: ch_rd_data  out  16  engine read data, broadcast to all channels.
REQ-016 Port: ch_done  out  NUM_CH  one-cycle pulse on successful completion.
REQ-017 Port: ch_err  out  NUM_CH  one-cycle pulse on timeout abort.
REQ-018 Port: eng_wr_start  out  1  one-cycle start pulse to the write engine.
REQ-019 Port: eng_rd_start  out  1  one-cycle start pulse to the read engine.
REQ-020 Port: eng_sec_addr  out  32  registered sector address of the granted channel.
REQ-021 Port: eng_wr_data  out  16  ch_wr_data of the granted channel, combinational mux.
REQ-022 Port: eng_wr_busy / eng_rd_busy  in  1 each  engine busy flags.
REQ-023 Port: eng_wr_req / eng_rd_val_en  in  1 each  engine data strobes.
REQ-024 Port: eng_rd_data  in  16  engine read data.
REQ-025 Port: arb_busy  out  1  high in any state other than IDLE.
REQ-026 Port: grant  out  GW  index of the currently or last granted channel.

Function
REQ-027 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, RUN, DONE and ERR.
REQ-028 IDLE: when sd_init_done=1 and ch_req!=0, the FSM SHALL select the first requesting channel at or after grant+1 (mod NUM_CH, round-robin), pulse ch_ack[sel], register grant, dir and address, and go to LAUNCH.
REQ-029 LAUNCH: the FSM SHALL assert eng_wr_start if dir=1, else eng_rd_start, for exactly one cycle, clear the counter, and go to WAIT_BUSY.
REQ-030 WAIT_BUSY: when the selected busy is 1 the FSM SHALL go to RUN and clear the counter; when the counter reaches START_TO it SHALL go to ERR; otherwise it SHALL increment the counter.
REQ-031 RUN: when the selected busy is 0 the FSM SHALL go to DONE; when the counter reaches BUSY_TO it SHALL go to ERR.
REQ-032 DONE: the FSM SHALL pulse ch_done[grant] and go to IDLE; ERR: the FSM SHALL pulse ch_err[grant] and go to IDLE.
REQ-033 Only the busy flag matching the registered dir SHALL be evaluated; the other SHALL be ignored.
REQ-034 ch_wr_req[i] SHALL equal eng_wr_req & (i==grant) & arb_busy, and ch_rd_val_en[i] SHALL equal eng_rd_val_en & (i==grant) & arb_busy; both are combinational.
REQ-035 Arbitration SHALL occur only in IDLE, so minimum request-to-request spacing is 5 cycles; requests arriving mid-transfer wait.
REQ-036 If sd_init_done falls during a transfer, the FSM SHALL continue the transfer; no new grant SHALL occur until sd_init_done returns to 1.
REQ-037 Deassertion of ch_req before ch_ack SHALL withdraw the request without side effects.

Reset
REQ-038 While rst=1 the FSM SHALL return to IDLE on the next clock edge, including mid-transfer, without issuing done or err pulses.
REQ-039 Reset SHALL set grant=NUM_CH-1 so that channel 0 has first priority, set counter=0 and eng_sec_addr=0, and drive all pulse outputs and arb_busy to 0.

Verification
REQ-040 Reset, then ch_req=4'b0101, both reads, with the engine busy for 10 cycles -> ch_ack[0] first, then ch_done[0], then ch_ack[2] and ch_done[2].
REQ-041 All four channels requesting continuously -> grant sequence 0,1,2,3,0.
REQ-042 Channel 1 write to addr 0x1234 with eng_wr_req pulsed 256 times -> eng_sec_addr=0x1234, ch_wr_req[1] pulsed 256 times, ch_wr_req[0,2,3] never pulsed.
REQ-043 Engine never raises busy -> ch_err[grant] exactly START_TO+1 cycles after WAIT_BUSY entry; the next request is then served.
REQ-044 rst asserted during RUN -> IDLE next cycle, no ch_done or ch_err pulse, grant=3.
REQ-045 sd_init_done=0 with ch_req=4'b1111 -> no ch_ack until sd_init_done=1.
